branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline.
- IF stage: indexes a direct-mapped BTB/BHT with PCF and supplies a predicted next-PC.
- EX stage: compares the prediction with the branch outcome and target from branch decision and ALU, raises mispredict with a redirect PC, and trains the tables.
- The hazard unit consumes MispredictE to flush D/E.

Parameters:
IDX_W, 6, log2 number of table entries (64).
TAG_W, 32-IDX_W-2, stored tag width = PC[31:IDX_W+2].

Ports:
clk  in  1  core clock.
rst_n  in  1  async active-low reset.
PCF  in  32  IF-stage PC.
PredTakenF  out  1  IF prediction taken.
PredTargetF  out  32  IF predicted target (valid when PredTakenF).
StallD  in  1  hold IF->ID prediction register.
FlushD  in  1  clear IF->ID prediction register.
StallE  in  1  hold ID->EX prediction register; also blocks table update.
FlushE  in  1  clear ID->EX prediction register.
PCE  in  32  EX-stage PC.
BranchTypeE  in  3  branch type in EX (Parameters.v encoding; NOBRANCH = not a conditional branch).
BranchE  in  1  actual taken from branch decision.
BrTargetE  in  32  computed branch target in EX.
MispredictE  out  1  EX-stage misprediction, combinational.
RedirectPCE  out  32  correct next PC when MispredictE.

Behaviour:
- Reset (async, rst_n=0):
  - All valid bits 0; all counters 2'b01 (weakly not-taken); pipeline registers 0.
  - PredTakenF=0, PredTargetF=0, MispredictE=0, RedirectPCE=0 for as long as rst_n is low and until the first post-reset lookup hits.
- Lookup (combinational, 0 cycles):
  - idx=PCF[IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==PCF[31:IDX_W+2].
  - PredTakenF = hit && ctr[idx][1].
  - PredTargetF = target[idx] when hit, else 0.
- Prediction pipeline: PredTaken/PredTarget registered F->D->E.
  - Stall holds the register; flush clears it to 0/0.
  - Flush has priority over stall.
- Resolution in EX (isBr = BranchTypeE != NOBRANCH):
  - isBr: MispredictE = (BranchE != PredTakenE) || (BranchE && PredTakenE && PredTargetE != BrTargetE).
  - !isBr: MispredictE = PredTakenE (aliased hit on a non-branch).
  - RedirectPCE = (isBr && BranchE) ? BrTargetE : PCE+4.
  - MispredictE is forced 0 while StallE=1.
- Training at posedge clk, only when StallE=0:
  - isBr, eidx=PCE[IDX_W+1:2]:
    - Counter saturates: BranchE ? min(ctr+1,3) : max(ctr-1,0).
    - If BranchE: write tag and target=BrTargetE, set valid.
    - If entry invalid or tag mismatch, initialise ctr to BranchE ? 2'b10 : 2'b01 instead of incrementing/decrementing.
    - Not taken with no valid entry: no allocation.
  - !isBr && PredTakenE: clear valid[eidx].
- Simultaneous lookup and update of the same index: lookup returns pre-update contents (read-before-write); the new value is visible the next cycle.
- PCE+4 wraps modulo 2^32.

Optional Feature:
BP_STATS_EN
- Defined: adds 32-bit outputs BrCount and MispCount.
  - BrCount increments on each trained branch (isBr && !StallE).
  - MispCount increments on each MispredictE.
  - Both saturate at 32'hFFFF_FFFF; async reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Parameters.v holds branch-type encodings (BEQ..BGEU, NOBRANCH) plus new macros: `BP_CTR_WNT 2'b01, `BP_CTR_WT 2'b10.
- Sub-module bp_table: storage arrays, async-read/sync-write, valid clear on rst_n.
- branch_predict_ctrl keeps the pipeline registers, mispredict logic and update policy.

Test Plan:
- Reset then PCF=0x100 -> PredTakenF=0, PredTargetF=0. Assert rst_n mid-run -> all entries invalid on the next lookup.
- BEQ at PCE=0x100, taken, BrTargetE=0x80, PredTakenE=0:
  - -> MispredictE=1, RedirectPCE=0x80.
  - After the edge, PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
- Same BEQ taken twice more, then not taken:
  - counter 2->3->3->2, prediction stays taken, only the last resolution mispredicts with RedirectPCE=0x104.
  - Next not-taken -> ctr=1, PredTakenF=0.
- Target change: trained entry 0x100->0x80, resolve taken with BrTargetE=0xC0 -> MispredictE=1, RedirectPCE=0xC0, next lookup target 0xC0.
- Alias: non-branch at PCE=0x100 with PredTakenE=1 -> MispredictE=1, RedirectPCE=0x104, valid cleared. With StallE=1 the same case gives MispredictE=0 and no table change.
- FlushE and StallE both asserted with PredTakenD=1 -> PredTakenE=0 next cycle. Same-index lookup and update in one cycle -> old value returned that cycle.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// rtl/branch_predict_ctrl_pkg.sv - shared types, encodings and counter helper for the branch predictor
package branch_predict_ctrl_pkg;

    localparam int BP_IDX_W = 6;

    // Branch-type encodings used by BranchTypeE
    localparam logic [2:0] BR_NOBRANCH = 3'd0;
    localparam logic [2:0] BR_BEQ      = 3'd1;
    localparam logic [2:0] BR_BNE      = 3'd2;
    localparam logic [2:0] BR_BLT      = 3'd3;
    localparam logic [2:0] BR_BGE      = 3'd4;
    localparam logic [2:0] BR_BLTU     = 3'd5;
    localparam logic [2:0] BR_BGEU     = 3'd6;

    // Counter values a fresh entry starts from
    localparam logic [1:0] BP_CTR_WNT = 2'b01;
    localparam logic [1:0] BP_CTR_WT  = 2'b10;

    // Two-bit saturating counter step
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bp_table.sv
// rtl/branch_predict_ctrl_bp_table.sv - direct-mapped BTB/BHT storage, two async read ports, one sync write
module bp_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic             valid_a,
    output logic [TAG_W-1:0] tag_a,
    output logic [31:0]      target_a,
    output logic [1:0]       ctr_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic             valid_b,
    output logic [TAG_W-1:0] tag_b,
    output logic [31:0]      target_b,
    output logic [1:0]       ctr_b,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [1:0]       wr_ctr,
    input  logic             wr_tt_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [1:0]       ctr_q [DEPTH];
    logic [1:0]       ctr_d [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [31:0]      target_mem [DEPTH];

    // Async reads: a same-cycle write is only visible after the edge
    assign valid_a  = valid_q[rd_idx_a];
    assign tag_a    = tag_mem[rd_idx_a];
    assign target_a = target_mem[rd_idx_a];
    assign ctr_a    = ctr_q[rd_idx_a];
    assign valid_b  = valid_q[rd_idx_b];
    assign tag_b    = tag_mem[rd_idx_b];
    assign target_b = target_mem[rd_idx_b];
    assign ctr_b    = ctr_q[rd_idx_b];

    // Next state of valid bits and counters
    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            ctr_d[wr_idx]   = wr_ctr;
        end
    end

    // Valid bits and counters reset so every entry starts invalid and weakly not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= BP_CTR_WNT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target payload; meaningless while the valid bit is clear, so no reset
    always_ff @(posedge clk) begin
        if (wr_en && wr_tt_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - branch predictor / redirect controller top; optional BP_STATS_EN adds statistics counters
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [31:0] PCE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] BrTargetE,
`ifdef BP_STATS_EN
    output logic [31:0] BrCount,
    output logic [31:0] MispCount,
`endif
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
);
    logic             valid_f, valid_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic [31:0]      target_f, target_e;
    logic [1:0]       ctr_f, ctr_e;
    logic             hit_f, hit_e, is_br;
    logic             upd_en, upd_valid, upd_tt_en;
    logic [1:0]       upd_ctr;

    logic        predd_taken_q, predd_taken_d;
    logic [31:0] predd_target_q, predd_target_d;
    logic        prede_taken_q, prede_taken_d;
    logic [31:0] prede_target_q, prede_target_d;

    bp_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_a  (PCF[IDX_W+1:2]),
        .valid_a   (valid_f),
        .tag_a     (tag_f),
        .target_a  (target_f),
        .ctr_a     (ctr_f),
        .rd_idx_b  (PCE[IDX_W+1:2]),
        .valid_b   (valid_e),
        .tag_b     (tag_e),
        .target_b  (target_e),
        .ctr_b     (ctr_e),
        .wr_en     (upd_en),
        .wr_idx    (PCE[IDX_W+1:2]),
        .wr_valid  (upd_valid),
        .wr_ctr    (upd_ctr),
        .wr_tt_en  (upd_tt_en),
        .wr_tag    (PCE[31:IDX_W+2]),
        .wr_target (BrTargetE)
    );

    assign hit_f       = valid_f && (tag_f == PCF[31:IDX_W+2]);
    assign hit_e       = valid_e && (tag_e == PCE[31:IDX_W+2]);
    assign is_br       = (BranchTypeE != BR_NOBRANCH);
    assign PredTakenF  = hit_f && ctr_f[1];
    assign PredTargetF = hit_f ? target_f : 32'd0;

    // Prediction pipeline F->D->E; flush wins over stall
    always_comb begin
        predd_taken_d  = predd_taken_q;
        predd_target_d = predd_target_q;
        prede_taken_d  = prede_taken_q;
        prede_target_d = prede_target_q;
        if (FlushD) begin
            predd_taken_d  = 1'b0;
            predd_target_d = 32'd0;
        end else if (!StallD) begin
            predd_taken_d  = PredTakenF;
            predd_target_d = PredTargetF;
        end
        if (FlushE) begin
            prede_taken_d  = 1'b0;
            prede_target_d = 32'd0;
        end else if (!StallE) begin
            prede_taken_d  = predd_taken_q;
            prede_target_d = predd_target_q;
        end
    end

    // Prediction pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predd_taken_q  <= 1'b0;
            predd_target_q <= 32'd0;
            prede_taken_q  <= 1'b0;
            prede_target_q <= 32'd0;
        end else begin
            predd_taken_q  <= predd_taken_d;
            predd_target_q <= predd_target_d;
            prede_taken_q  <= prede_taken_d;
            prede_target_q <= prede_target_d;
        end
    end

    // EX resolution: a stalled EX never redirects; redirect PC reads 0 unless redirecting
    always_comb begin
        MispredictE = 1'b0;
        RedirectPCE = 32'd0;
        if (rst_n && !StallE) begin
            if (is_br) begin
                MispredictE = (BranchE != prede_taken_q) ||
                              (BranchE && prede_taken_q && (prede_target_q != BrTargetE));
            end else begin
                MispredictE = prede_taken_q;
            end
        end
        if (MispredictE) begin
            RedirectPCE = (is_br && BranchE) ? BrTargetE : PCE + 32'd4;
        end
    end

    // Table training policy for the entry selected by PCE
    always_comb begin
        upd_en    = 1'b0;
        upd_valid = 1'b0;
        upd_ctr   = ctr_e;
        upd_tt_en = 1'b0;
        if (!StallE) begin
            if (is_br) begin
                if (hit_e) begin
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_ctr   = ctr_step(ctr_e, BranchE);
                    upd_tt_en = BranchE;
                end else if (BranchE) begin
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_ctr   = BP_CTR_WT;
                    upd_tt_en = 1'b1;
                end else if (valid_e) begin
                    // Not-taken against another branch's entry: only the counter is reset
                    upd_en    = 1'b1;
                    upd_valid = 1'b1;
                    upd_ctr   = BP_CTR_WNT;
                end
            end else if (prede_taken_q) begin
                // A non-branch predicted taken means an alias; drop the entry
                upd_en    = 1'b1;
                upd_valid = 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] misp_count_q, misp_count_d;

    // Saturating statistics counters
    always_comb begin
        br_count_d   = br_count_q;
        misp_count_d = misp_count_q;
        if (is_br && !StallE && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (MispredictE && (misp_count_q != 32'hFFFF_FFFF)) begin
            misp_count_d = misp_count_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q   <= 32'd0;
            misp_count_q <= 32'd0;
        end else begin
            br_count_q   <= br_count_d;
            misp_count_q <= misp_count_d;
        end
    end

    assign BrCount   = br_count_q;
    assign MispCount = misp_count_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - self-checking bench for branch_predict_ctrl with a table-level model
module tb_branch_predict_ctrl;
    import branch_predict_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PCF = 32'd0;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        StallD = 1'b0, FlushD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
    logic [31:0] PCE = 32'd0;
    logic [2:0]  BranchTypeE = BR_NOBRANCH;
    logic        BranchE = 1'b0;
    logic [31:0] BrTargetE = 32'd0;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
    logic [31:0] BrCount, MispCount;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .PCE         (PCE),
        .BranchTypeE (BranchTypeE),
        .BranchE     (BranchE),
        .BrTargetE   (BrTargetE),
`ifdef BP_STATS_EN
        .BrCount     (BrCount),
        .MispCount   (MispCount),
`endif
        .MispredictE (MispredictE),
        .RedirectPCE (RedirectPCE)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: 64-entry table kept as plain arrays, prediction pipeline as two stage slots
    bit          m_valid [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    bit          m_d_taken, m_e_taken;
    logic [31:0] m_d_tgt, m_e_tgt;

    always @(negedge clk) begin
        int fi, ei;
        bit f_hit, e_hit, br, exp_taken, exp_misp;
        logic [31:0] exp_tgt, exp_redir;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            m_d_taken = 0; m_d_tgt = 0; m_e_taken = 0; m_e_tgt = 0;
            check("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
            check("rst_PredTargetF", PredTargetF, 32'd0);
            check("rst_MispredictE", {31'd0, MispredictE}, 32'd0);
            check("rst_RedirectPCE", RedirectPCE, 32'd0);
        end else begin
            fi = (PCF / 4) % 64;
            ei = (PCE / 4) % 64;
            f_hit = m_valid[fi] && (m_tag[fi] == PCF[31:8]);
            e_hit = m_valid[ei] && (m_tag[ei] == PCE[31:8]);
            exp_taken = f_hit && (m_ctr[fi] >= 2);
            exp_tgt = f_hit ? m_tgt[fi] : 32'd0;
            br = (BranchTypeE != BR_NOBRANCH);
            if (StallE) exp_misp = 0;
            else if (br) exp_misp = (BranchE != m_e_taken) || (BranchE && m_e_taken && m_e_tgt != BrTargetE);
            else exp_misp = m_e_taken;
            exp_redir = !exp_misp ? 32'd0 : (br && BranchE) ? BrTargetE : PCE + 32'd4;
            check("PredTakenF", {31'd0, PredTakenF}, {31'd0, exp_taken});
            check("PredTargetF", PredTargetF, exp_tgt);
            check("MispredictE", {31'd0, MispredictE}, {31'd0, exp_misp});
            check("RedirectPCE", RedirectPCE, exp_redir);
            // state the DUT will hold after the coming edge
            if (!StallE) begin
                if (br) begin
                    if (e_hit) begin
                        m_ctr[ei] = BranchE ? ((m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3)
                                            : ((m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0);
                        if (BranchE) m_tgt[ei] = BrTargetE;
                    end else if (BranchE) begin
                        m_valid[ei] = 1; m_tag[ei] = PCE[31:8]; m_tgt[ei] = BrTargetE; m_ctr[ei] = 2;
                    end else if (m_valid[ei]) begin
                        m_ctr[ei] = 1;
                    end
                end else if (m_e_taken) begin
                    m_valid[ei] = 0;
                end
            end
            if (FlushE) begin m_e_taken = 0; m_e_tgt = 0; end
            else if (!StallE) begin m_e_taken = m_d_taken; m_e_tgt = m_d_tgt; end
            if (FlushD) begin m_d_taken = 0; m_d_tgt = 0; end
            else if (!StallD) begin m_d_taken = exp_taken; m_d_tgt = exp_tgt; end
        end
    end

    // One cycle of stimulus: inputs change just after the edge, literal checks follow mid-cycle
    task automatic cyc(input logic [31:0] pcf, input logic [31:0] pce, input logic [2:0] bt,
                       input logic br, input logic [31:0] tgt,
                       input logic sd, input logic fd, input logic se, input logic fe);
        @(posedge clk);
        #2;
        PCF = pcf; PCE = pce; BranchTypeE = bt; BranchE = br; BrTargetE = tgt;
        StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] IDLE = 32'h0000_2004;

    initial begin
        PCF = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("L_reset_taken", {31'd0, PredTakenF}, 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk); #1;
        check("L_post_reset_taken", {31'd0, PredTakenF}, 32'd0);
        check("L_post_reset_target", PredTargetF, 32'd0);

        cyc(IDLE, 32'h100, BR_BEQ, 1, 32'h80, 0, 0, 0, 0);
        check("L_first_misp", {31'd0, MispredictE}, 32'd1);
        check("L_first_redir", RedirectPCE, 32'h80);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_trained_taken", {31'd0, PredTakenF}, 32'd1);
        check("L_trained_target", PredTargetF, 32'h80);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        cyc(32'h100, 32'h100, BR_BEQ, 1, 32'h80, 0, 0, 0, 0);
        check("L_taken2_misp", {31'd0, MispredictE}, 32'd0);
        cyc(32'h100, 32'h100, BR_BEQ, 1, 32'h80, 0, 0, 0, 0);
        check("L_taken3_misp", {31'd0, MispredictE}, 32'd0);
        cyc(32'h100, 32'h100, BR_BEQ, 0, 32'h80, 0, 0, 0, 0);
        check("L_nt_misp", {31'd0, MispredictE}, 32'd1);
        check("L_nt_redir", RedirectPCE, 32'h104);
        cyc(32'h100, 32'h100, BR_BEQ, 0, 32'h80, 0, 0, 0, 0);
        check("L_ctr2_taken", {31'd0, PredTakenF}, 32'd1);
        // stalled alias, flush+stall on E and D together
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 1, 1, 1);
        check("L_ctr1_taken", {31'd0, PredTakenF}, 32'd0);
        check("L_stalled_alias_misp", {31'd0, MispredictE}, 32'd0);
        cyc(IDLE, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_flushE_misp", {31'd0, MispredictE}, 32'd0);
        cyc(IDLE, 32'h100, BR_BEQ, 1, 32'hC0, 0, 0, 0, 0);
        check("L_tchg_misp", {31'd0, MispredictE}, 32'd1);
        check("L_tchg_redir", RedirectPCE, 32'hC0);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_tchg_target", PredTargetF, 32'hC0);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        cyc(IDLE, 32'h100, BR_BEQ, 1, 32'h80, 0, 0, 0, 0);
        check("L_tgt_only_misp", {31'd0, MispredictE}, 32'd1);
        check("L_tgt_only_redir", RedirectPCE, 32'h80);
        cyc(32'h100, 32'h100, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_alias_misp", {31'd0, MispredictE}, 32'd1);
        check("L_alias_redir", RedirectPCE, 32'h104);
        check("L_rbw_taken", {31'd0, PredTakenF}, 32'd1);
        check("L_rbw_target", PredTargetF, 32'h80);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_alias_cleared", {31'd0, PredTakenF}, 32'd0);
        cyc(IDLE, 32'h100, BR_BNE, 0, 32'h0, 0, 0, 0, 0);
        check("L_nt_invalid_misp", {31'd0, MispredictE}, 32'd1);
        cyc(32'h100, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_no_alloc", {31'd0, PredTakenF}, 32'd0);
        cyc(IDLE, 32'hFFFF_FFFC, BR_BEQ, 1, 32'h40, 0, 0, 0, 0);
        cyc(32'hFFFF_FFFC, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        check("L_top_target", PredTargetF, 32'h40);
        cyc(IDLE, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        cyc(IDLE, 32'hFFFF_FFFC, BR_BEQ, 0, 32'h40, 0, 0, 0, 0);
        check("L_wrap_misp", {31'd0, MispredictE}, 32'd1);
        check("L_wrap_redir", RedirectPCE, 32'h0);
        // D-stage stall holds a taken prediction while F moves on
        cyc(32'hFFFF_FFFC, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        cyc(IDLE, IDLE, BR_NOBRANCH, 0, 0, 1, 0, 0, 0);
        cyc(IDLE, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        cyc(IDLE, IDLE, BR_NOBRANCH, 0, 0, 0, 0, 0, 0);
        // mid-run reset wipes the table
        @(posedge clk); #2; rst_n = 1'b0; PCF = 32'hFFFF_FFFC;
        @(negedge clk); #1;
        check("L_midrst_taken", {31'd0, PredTakenF}, 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk); #1;
        check("L_after_rst_taken", {31'd0, PredTakenF}, 32'd0);
        check("L_after_rst_target", PredTargetF, 32'd0);
        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
